acc_pixop: RTL and testbench

- Parametrised successor of the task-3 inversion accelerator: streams a packed 8-bit greyscale image (4 pixels per 32-bit word) from a source region to a destination region of the shared data memory.
- Applies one of four run-time-selectable per-pixel operations.
- Pipelined read/write schedule: one word per 2 cycles.
- Sits beside the CPU on the same memory bus; controlled by a start/finish handshake.

---
 rtl/acc_pixop.sv | 236 +++++++++++++++++++++++
 tb/tb_acc_pixop.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_pixop.sv
// acc_pixop -- streaming per-pixel operator for packed 8-bit greyscale images.
//
// Reads WORDS 32-bit words (4 pixels each) starting at SRC_BASE, applies
// one of four per-byte operations and writes the results starting at
// DST_BASE. Reads and writes are interleaved on the shared memory bus, so
// one word is moved every 2 cycles. A run takes exactly 2*WORDS bus cycles.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   start         run request (level); a new run needs start low in IDLE
//                 first, then high
//   mode          00 invert, 01 threshold, 10 saturating offset, 11 copy
//   thr           threshold value (unsigned)
//   offset        signed 9-bit brightness offset
//   addr          memory word address
//   dataR         memory read data (valid the cycle after a read request)
//   dataW         memory write data
//   en, we        memory request / write enable
//   busy          high from the first read through the last write
//   finish        completion flag, held until start drops
module acc_pixop #(
  parameter int IMG_W    = 352,
  parameter int IMG_H    = 288,
  parameter int ADDR_W   = 16,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = IMG_W*IMG_H/4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        thr,
  input  logic [8:0]        offset,
  output logic [ADDR_W-1:0] addr,
  input  logic [31:0]       dataR,
  output logic [31:0]       dataW,
  output logic              en,
  output logic              we,
  output logic              busy,
  output logic              finish
);

  localparam int WORDS = IMG_W*IMG_H/4;
  // Counters must be able to hold WORDS itself so they never wrap.
  localparam int CNT_W = $clog2(WORDS+1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  rd_cnt_reg, rd_cnt_next;  // index of the next word to read
  logic [CNT_W-1:0]  wr_cnt_reg, wr_cnt_next;  // index of the next word to write
  logic              armed_reg, armed_next;    // start has been seen low in IDLE
  logic [1:0]        mode_reg, mode_next;
  logic [7:0]        thr_reg, thr_next;
  logic [8:0]        off_reg, off_next;
  logic              cap_reg, cap_next;        // dataR is valid this cycle
  logic [31:0]       pix_reg, pix_next;        // last captured source word
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       dataw_reg, dataw_next;
  logic              en_reg, en_next;
  logic              we_reg, we_next;
  logic              busy_reg, busy_next;
  logic              finish_reg, finish_next;

  assign addr   = addr_reg;
  assign dataW  = dataw_reg;
  assign en     = en_reg;
  assign we     = we_reg;
  assign busy   = busy_reg;
  assign finish = finish_reg;

  // Source word for the write being scheduled. When the read data is on the
  // bus right now (first and last words of a run) it is used directly;
  // otherwise it was captured one cycle earlier into pix_reg.
  logic [31:0] src_word;
  logic [31:0] f_word;
  assign src_word = cap_reg ? dataR : pix_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0]        p;
      logic signed [9:0] sum;
      logic [7:0]        res;

      assign p   = src_word[8*gi +: 8];
      // 10-bit signed covers -256..510, so the clamp sees the true sum.
      assign sum = $signed({2'b00, p}) + $signed({off_reg[8], off_reg});

      always_comb begin
        res = p;
        case (mode_reg)
          2'b00: res = 8'hFF - p;
          2'b01: res = (p >= thr_reg) ? 8'hFF : 8'h00;
          2'b10: begin
            if (sum[9])      res = 8'h00;
            else if (sum[8]) res = 8'hFF;
            else             res = sum[7:0];
          end
          default: res = p;
        endcase
      end

      assign f_word[8*gi +: 8] = res;
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    rd_cnt_next = rd_cnt_reg;
    wr_cnt_next = wr_cnt_reg;
    armed_next  = armed_reg;
    mode_next   = mode_reg;
    thr_next    = thr_reg;
    off_next    = off_reg;
    cap_next    = en_reg & ~we_reg;
    pix_next    = cap_reg ? dataR : pix_reg;
    addr_next   = '0;
    dataw_next  = '0;
    en_next     = 1'b0;
    we_next     = 1'b0;
    busy_next   = 1'b0;
    finish_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && armed_reg) begin
          // Launch: the next cycle is R0.
          state_next  = PRIME;
          mode_next   = mode;
          thr_next    = thr;
          off_next    = offset;
          armed_next  = 1'b0;
          rd_cnt_next = CNT_ONE;
          wr_cnt_next = '0;
          addr_next   = SRC_A;
          en_next     = 1'b1;
          busy_next   = 1'b1;
        end else if (!start) begin
          armed_next = 1'b1;
        end
      end

      PRIME: begin
        en_next   = 1'b1;
        busy_next = 1'b1;
        if (rd_cnt_reg == CNT_ONE) begin
          // Currently R0: issue R1.
          addr_next   = SRC_A + ADDR_W'(rd_cnt_reg);
          rd_cnt_next = rd_cnt_reg + CNT_ONE;
        end else begin
          // Currently R1: issue W0.
          addr_next   = DST_A + ADDR_W'(wr_cnt_reg);
          we_next     = 1'b1;
          dataw_next  = f_word;
          wr_cnt_next = wr_cnt_reg + CNT_ONE;
          state_next  = RUN;
        end
      end

      RUN: begin
        en_next   = 1'b1;
        busy_next = 1'b1;
        if (we_reg && rd_cnt_reg != CNT_LAST) begin
          addr_next   = SRC_A + ADDR_W'(rd_cnt_reg);
          rd_cnt_next = rd_cnt_reg + CNT_ONE;
        end else begin
          addr_next   = DST_A + ADDR_W'(wr_cnt_reg);
          we_next     = 1'b1;
          dataw_next  = f_word;
          wr_cnt_next = wr_cnt_reg + CNT_ONE;
          // A write after a write means all reads are done: this is the
          // final word.
          if (we_reg) state_next = DRAIN;
        end
      end

      DRAIN: begin
        state_next  = DONE;
        finish_next = 1'b1;
      end

      DONE: begin
        if (start) begin
          finish_next = 1'b1;
        end else begin
          state_next = IDLE;
          armed_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      armed_reg  <= 1'b0;
      mode_reg   <= '0;
      thr_reg    <= '0;
      off_reg    <= '0;
      cap_reg    <= 1'b0;
      pix_reg    <= '0;
      addr_reg   <= '0;
      dataw_reg  <= '0;
      en_reg     <= 1'b0;
      we_reg     <= 1'b0;
      busy_reg   <= 1'b0;
      finish_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rd_cnt_reg <= rd_cnt_next;
      wr_cnt_reg <= wr_cnt_next;
      armed_reg  <= armed_next;
      mode_reg   <= mode_next;
      thr_reg    <= thr_next;
      off_reg    <= off_next;
      cap_reg    <= cap_next;
      pix_reg    <= pix_next;
      addr_reg   <= addr_next;
      dataw_reg  <= dataw_next;
      en_reg     <= en_next;
      we_reg     <= we_next;
      busy_reg   <= busy_next;
      finish_reg <= finish_next;
    end
  end

endmodule

// File: tb/tb_acc_pixop.sv
// Testbench for acc_pixop: a small 8x2 instance for directed and random
// runs, and a full-size 352x288 instance for the long copy run.
module tb_acc_pixop;

  localparam int SW = 8;
  localparam int SH = 2;
  localparam int SN = SW*SH/4;
  localparam int BW = 352;
  localparam int BH = 288;
  localparam int BN = BW*BH/4;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          s_start, b_start;
  logic [1:0]    s_mode, b_mode;
  logic [7:0]    s_thr, b_thr;
  logic [8:0]    s_off, b_off;
  logic [AW-1:0] s_addr, b_addr;
  logic [31:0]   s_dataR, s_dataW, b_dataR, b_dataW;
  logic          s_en, s_we, s_busy, s_finish;
  logic          b_en, b_we, b_busy, b_finish;

  acc_pixop #(.IMG_W(SW), .IMG_H(SH), .ADDR_W(AW), .SRC_BASE(0), .DST_BASE(SN)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .thr(s_thr),
    .offset(s_off), .addr(s_addr), .dataR(s_dataR), .dataW(s_dataW),
    .en(s_en), .we(s_we), .busy(s_busy), .finish(s_finish)
  );

  acc_pixop #(.IMG_W(BW), .IMG_H(BH), .ADDR_W(AW), .SRC_BASE(0), .DST_BASE(BN)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .mode(b_mode), .thr(b_thr),
    .offset(b_off), .addr(b_addr), .dataR(b_dataR), .dataW(b_dataW),
    .en(b_en), .we(b_we), .busy(b_busy), .finish(b_finish)
  );

  // Memories: source arrays filled by the bench, destination arrays written
  // only by the DUTs. Read data is valid for one cycle, garbage otherwise.
  logic [31:0] s_src [SN];
  logic [31:0] s_dst [SN];
  logic [31:0] b_src [BN];
  logic [31:0] b_dst [BN];
  int s_bad = 0;
  int b_bad = 0;

  always @(posedge clk) begin
    s_dataR <= $urandom();
    if (s_en) begin
      if (s_we) begin
        if (int'(s_addr) >= SN && int'(s_addr) < 2*SN) s_dst[int'(s_addr) - SN] <= s_dataW;
        else s_bad <= s_bad + 1;
      end else begin
        if (int'(s_addr) < SN) s_dataR <= s_src[int'(s_addr)];
        else s_bad <= s_bad + 1;
      end
    end
  end

  always @(posedge clk) begin
    b_dataR <= $urandom();
    if (b_en) begin
      if (b_we) begin
        if (int'(b_addr) >= BN && int'(b_addr) < 2*BN) b_dst[int'(b_addr) - BN] <= b_dataW;
        else b_bad <= b_bad + 1;
      end else begin
        if (int'(b_addr) < BN) b_dataR <= b_src[int'(b_addr)];
        else b_bad <= b_bad + 1;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  int cyc = 0;
  int s_runs = 0;
  int s_busy_rise = 0, s_fin_rise = 0, b_busy_rise = 0, b_fin_rise = 0;
  logic s_busy_q = 1'b0, s_fin_q = 1'b0, b_busy_q = 1'b0, b_fin_q = 1'b0;
  logic [17:0] s_trace [$];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    s_busy_q <= s_busy;
    s_fin_q  <= s_finish;
    b_busy_q <= b_busy;
    b_fin_q  <= b_finish;
    if (s_busy) s_trace.push_back({s_en, s_we, s_addr});
    if (s_busy && !s_busy_q) begin
      s_busy_rise <= cyc;
      s_runs      <= s_runs + 1;
    end
    if (s_finish && !s_fin_q) s_fin_rise <= cyc;
    if (b_busy && !b_busy_q) b_busy_rise <= cyc;
    if (b_finish && !b_fin_q) b_fin_rise <= cyc;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-byte rules with plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [7:0] t,
                                        input logic [8:0] o, input logic [31:0] w);
    logic [31:0] r;
    int p, v, off;
    off = (int'(o) >= 256) ? int'(o) - 512 : int'(o);
    r = '0;
    for (int k = 0; k < 4; k++) begin
      p = int'(w[8*k +: 8]);
      case (m)
        2'd0: v = 255 - p;
        2'd1: v = (p >= int'(t)) ? 255 : 0;
        2'd2: begin
          v = p + off;
          if (v < 0) v = 0;
          if (v > 255) v = 255;
        end
        default: v = p;
      endcase
      r[8*k +: 8] = v[7:0];
    end
    return r;
  endfunction

  // One complete run on the small instance, with all checks.
  task automatic run_small(input string tag, input logic [1:0] m, input logic [7:0] t,
                           input logic [8:0] o, input bit drop_mid);
    logic [31:0] exp_w [SN];
    logic [17:0] exp_tr [$];
    logic [17:0] obs;
    int base, runs0, n;

    for (int k = 0; k < SN; k++) exp_w[k] = model(m, t, o, s_src[k]);
    exp_tr.push_back({2'b10, AW'(0)});
    for (int i = 1; i < SN; i++) begin
      exp_tr.push_back({2'b10, AW'(i)});
      exp_tr.push_back({2'b11, AW'(SN + i - 1)});
    end
    exp_tr.push_back({2'b11, AW'(2*SN - 1)});

    s_start = 1'b0;
    @(negedge clk);
    base  = s_trace.size();
    runs0 = s_runs;
    s_mode = m; s_thr = t; s_off = o; s_start = 1'b1;
    @(negedge clk);
    // Controls change after launch; the run must keep the latched values.
    s_mode = m + 2'd1; s_thr = ~t; s_off = ~o;
    n = 0;
    while (!s_finish && n < 4*SN + 20) begin
      @(negedge clk);
      n++;
      if (drop_mid && n == 3) s_start = 1'b0;
    end
    check({tag, "_finish_seen"}, 64'(s_finish), 64'd1);

    if (drop_mid) begin
      @(negedge clk);
      check({tag, "_finish_drop"}, 64'(s_finish), 64'd0);
    end else begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        check($sformatf("%s_hold%0d", tag, h), {61'd0, s_finish, s_busy, s_en}, 64'b100);
      end
      check({tag, "_no_retrigger"}, 64'(s_runs - runs0), 64'd1);
      s_start = 1'b0;
      @(negedge clk);
      check({tag, "_finish_drop"}, 64'(s_finish), 64'd0);
    end

    check({tag, "_busy_cycles"}, 64'(s_trace.size() - base), 64'(2*SN));
    check({tag, "_latency"}, 64'(s_fin_rise - s_busy_rise), 64'(2*SN));
    for (int j = 0; j < 2*SN; j++) begin
      obs = (base + j < s_trace.size()) ? s_trace[base + j] : 18'h3FFFF;
      check($sformatf("%s_bus%0d", tag, j), 64'(obs), 64'(exp_tr[j]));
    end
    for (int k = 0; k < SN; k++)
      check($sformatf("%s_dst%0d", tag, k), 64'(s_dst[k]), 64'(exp_w[k]));
    $display("run %s mode=%0d thr=%02h off=%03h src0=%08h dst0=%08h",
             tag, m, t, o, s_src[0], s_dst[0]);
  endtask

  initial begin
    logic       en_seen;
    int         n, mism;
    logic [1:0] rm;

    reset = 1'b1;
    s_start = 1'b0; s_mode = '0; s_thr = '0; s_off = '0;
    b_start = 1'b0; b_mode = '0; b_thr = '0; b_off = '0;
    repeat (3) @(negedge clk);
    check("rst_small", {12'd0, s_addr, s_dataW, s_en, s_we, s_busy, s_finish}, 64'd0);
    check("rst_big",   {12'd0, b_addr, b_dataW, b_en, b_we, b_busy, b_finish}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed test-plan words in word 0, random data elsewhere.
    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    s_src[0] = 32'h00FF1080;
    run_small("invert", 2'd0, 8'h00, 9'h000, 1'b0);
    check("invert_plan_word", 64'(s_dst[0]), 64'h0000_0000_FF00_EF7F);

    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    s_src[0] = 32'h7F80FF00;
    run_small("thresh", 2'd1, 8'h80, 9'h000, 1'b0);
    check("thresh_plan_word", 64'(s_dst[0]), 64'h0000_0000_00FF_FF00);

    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    s_src[0] = 32'hC8640A00;
    run_small("off_pos", 2'd2, 8'h00, 9'd100, 1'b0);
    check("off_pos_plan_word", 64'(s_dst[0]), 64'h0000_0000_FFC8_6E64);

    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    s_src[0] = 32'hC8640A00;
    run_small("off_neg", 2'd2, 8'h00, 9'h19C, 1'b0);
    check("off_neg_plan_word", 64'(s_dst[0]), 64'h0000_0000_6400_0000);

    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    run_small("copy", 2'd3, 8'h00, 9'h000, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < SN; k++) s_src[k] = $urandom();
      rm = 2'($urandom_range(0, 3));
      run_small($sformatf("rand%0d", r), rm, 8'($urandom()), 9'($urandom()), 1'b0);
    end

    // start dropped mid-run: the run still completes.
    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    run_small("drop_mid", 2'd2, 8'h00, 9'($urandom()), 1'b1);

    // Reset at cycle 5 of a run, with start still high afterwards.
    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    s_start = 1'b0;
    @(negedge clk);
    s_mode = 2'd0; s_start = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("midrst_outputs", {12'd0, s_addr, s_dataW, s_en, s_we, s_busy, s_finish}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    en_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      en_seen = en_seen | s_en | s_busy;
    end
    check("midrst_no_activity", 64'(en_seen), 64'd0);
    $display("run midrst reset applied at cycle 5");

    for (int k = 0; k < SN; k++) s_src[k] = $urandom();
    run_small("after_rst", 2'd0, 8'h00, 9'h000, 1'b0);
    check("small_bad_access", 64'(s_bad), 64'd0);

    // Full-size copy run.
    for (int k = 0; k < BN; k++) b_src[k] = $urandom();
    b_mode = 2'd3; b_start = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    n = 0;
    while (!b_finish && n < 2*BN + 50) begin
      @(negedge clk);
      n++;
    end
    check("big_finish_seen", 64'(b_finish), 64'd1);
    repeat (2) @(negedge clk);
    check("big_finish_hold", {62'd0, b_finish, b_busy}, 64'b10);
    check("big_latency", 64'(b_fin_rise - b_busy_rise), 64'(2*BN));
    mism = 0;
    for (int k = 0; k < BN; k++) if (b_dst[k] !== b_src[k]) mism++;
    check("big_copy_mismatches", 64'(mism), 64'd0);
    check("big_first_word", 64'(b_dst[0]), 64'(b_src[0]));
    check("big_last_word", 64'(b_dst[BN-1]), 64'(b_src[BN-1]));
    check("big_bad_access", 64'(b_bad), 64'd0);
    b_start = 1'b0;
    @(negedge clk);
    check("big_finish_drop", 64'(b_finish), 64'd0);
    $display("run big_copy words=%0d last=%08h", BN, b_dst[BN-1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
